// File: rtl/face_burst_reader.sv
// Burst-read initiator: fetches packed 24-word face records from RAM and streams them
// word-by-word to the vertex stage through a registered FIFO with valid/ready backpressure.
module face_burst_reader #(
    parameter int ADDR_W     = 32,
    parameter int FACE_WORDS = 24,
    parameter int FIFO_DEPTH = 32,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              iStart,
    input  logic [ADDR_W-1:0] iBaseAddress,
    input  logic [CNT_W-1:0]  iFaceCount,
    output logic              oBusy,
    output logic              oDone,
    output logic              oRead,
    output logic [ADDR_W-1:0] oAddress,
    output logic [7:0]        oBurstcount,
    input  logic              iWaitrequest,
    input  logic [31:0]       iData,
    input  logic              iDatavalid,
    output logic [31:0]       oWordData,
    output logic              oWordValid,
    input  logic              iWordReady,
    output logic [4:0]        oWordIdx,
    output logic              oWordLast,
    output logic              oOverflow
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_RECV, S_WAIT, S_DRAIN, S_FIN
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [ADDR_W-1:0]  r_base;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   r_idx;
    logic [7:0]         r_beat;
    logic [31:0]        r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wptr;
    logic [PTR_W-1:0]   r_rptr;
    logic [LVL_W-1:0]   r_level;
    logic [4:0]         r_word_idx;
    logic               r_overflow;

    logic [CNT_W-1:0]   w_idx_next;
    logic [ADDR_W-1:0]  w_idx_a;
    logic [ADDR_W-1:0]  w_addr;
    logic               w_last_beat;
    logic               w_full;
    logic               w_valid;
    logic               w_room;
    logic               w_push;
    logic               w_pop;

    assign w_idx_next  = r_idx + CNT_W'(1);
    // 96-byte stride as 64 + 32, wrapping modulo the address width
    assign w_idx_a     = ADDR_W'(r_idx);
    assign w_addr      = r_base + (w_idx_a << 6) + (w_idx_a << 5);
    assign w_last_beat = iDatavalid && (r_beat == 8'(FACE_WORDS - 1));
    assign w_full      = (r_level == LVL_W'(FIFO_DEPTH));
    assign w_valid     = (r_level != '0);
    assign w_room      = (r_level <= LVL_W'(FIFO_DEPTH - FACE_WORDS));
    assign w_push      = (r_state == S_RECV) && iDatavalid && !w_full;
    assign w_pop       = w_valid && iWordReady;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (iStart) w_next = (iFaceCount != '0) ? S_REQ : S_FIN;
            S_REQ:   if (!iWaitrequest) w_next = S_RECV;
            S_RECV:  if (w_last_beat) w_next = (w_idx_next < r_count) ? S_WAIT : S_DRAIN;
            S_WAIT:  if (w_room) w_next = S_REQ;
            S_DRAIN: if (!w_valid) w_next = S_FIN;
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        oBusy       = (r_state != S_IDLE);
        oDone       = (r_state == S_FIN);
        oRead       = (r_state == S_REQ);
        oAddress    = '0;
        oBurstcount = '0;
        if (r_state == S_REQ) begin
            oAddress    = w_addr;
            oBurstcount = 8'(FACE_WORDS);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_base     <= '0;
            r_count    <= '0;
            r_idx      <= '0;
            r_beat     <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
            r_word_idx <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (r_state == S_IDLE && iStart) begin
                r_base  <= iBaseAddress;
                r_count <= iFaceCount;
                r_idx   <= '0;
            end
            if (r_state == S_REQ) begin
                r_beat <= '0;
            end else if (r_state == S_RECV && iDatavalid) begin
                if (w_last_beat) begin
                    r_beat <= '0;
                    r_idx  <= w_idx_next;
                end else begin
                    r_beat <= r_beat + 8'd1;
                end
            end
            if (w_push) begin
                r_wptr <= (r_wptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr     <= (r_rptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_rptr + PTR_W'(1);
                r_word_idx <= (r_word_idx == 5'(FACE_WORDS - 1)) ? '0 : r_word_idx + 5'd1;
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + LVL_W'(1);
            end else if (!w_push && w_pop) begin
                r_level <= r_level - LVL_W'(1);
            end
            // Beats outside a burst or into a full FIFO are lost; IDLE ignores stray beats
            if (iDatavalid && r_state != S_IDLE && (r_state != S_RECV || w_full)) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= iData;
        end
    end

    assign oWordValid = w_valid;
    assign oWordData  = w_valid ? r_mem[r_rptr] : '0;
    assign oWordIdx   = r_word_idx;
    assign oWordLast  = (r_word_idx == 5'(FACE_WORDS - 1));
    assign oOverflow  = r_overflow;

endmodule

// File: tb/tb_face_burst_reader.sv
// Directed bench for face_burst_reader with a behavioural burst RAM and a word scoreboard.
module tb_face_burst_reader;
    logic        clk;
    logic        reset;
    logic        iStart;
    logic [31:0] iBaseAddress;
    logic [15:0] iFaceCount;
    logic        oBusy;
    logic        oDone;
    logic        oRead;
    logic [31:0] oAddress;
    logic [7:0]  oBurstcount;
    logic        iWaitrequest;
    logic [31:0] iData;
    logic        iDatavalid;
    logic [31:0] oWordData;
    logic        oWordValid;
    logic        iWordReady;
    logic [4:0]  oWordIdx;
    logic        oWordLast;
    logic        oOverflow;

    face_burst_reader dut (
        .clk(clk), .reset(reset), .iStart(iStart), .iBaseAddress(iBaseAddress),
        .iFaceCount(iFaceCount), .oBusy(oBusy), .oDone(oDone), .oRead(oRead),
        .oAddress(oAddress), .oBurstcount(oBurstcount), .iWaitrequest(iWaitrequest),
        .iData(iData), .iDatavalid(iDatavalid), .oWordData(oWordData),
        .oWordValid(oWordValid), .iWordReady(iWordReady), .oWordIdx(oWordIdx),
        .oWordLast(oWordLast), .oOverflow(oOverflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic [4:0]  idx;
    } sb_t;

    sb_t         sb_q[$];
    logic [31:0] exp_req[$];
    int checks = 0, failures = 0;
    int done_cnt = 0, acc_cnt = 0, pops = 0, read_cycles = 0, stall_cnt = 0, beats_drv = 0;
    int pend_left = 0, pend_k = 0, pend_delay = 0, wait_left = 0;
    bit stray = 0, beat_gap = 0, gap_tog = 0;
    logic [31:0] pend_addr, pend_exp;
    logic        s_busy, s_done, s_read, s_wv, s_last, s_ovf;
    logic [31:0] s_addr, s_wdata;
    logic [7:0]  s_bc;
    logic [4:0]  s_widx;

    function automatic logic [31:0] ram_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A3C, a[15:0] + 16'h1111};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample outputs at the falling edge, then drive inputs just after the rising edge
    task automatic tick();
        sb_t e;
        logic [31:0] ea;
        @(negedge clk);
        s_busy = oBusy; s_done = oDone; s_read = oRead; s_addr = oAddress; s_bc = oBurstcount;
        s_wv = oWordValid; s_wdata = oWordData; s_widx = oWordIdx; s_last = oWordLast; s_ovf = oOverflow;
        if (oDone === 1'b1) done_cnt++;
        if (oRead === 1'b1) read_cycles++;
        if (oRead === 1'b1 && iWaitrequest) begin
            stall_cnt++;
            if (exp_req.size() != 0) chk("stall_addr", oAddress, exp_req[0]);
            chk("stall_bc", oBurstcount, 24);
            if (wait_left > 0) wait_left--;
        end
        if (oRead === 1'b1 && !iWaitrequest) begin
            acc_cnt++;
            pend_exp = oAddress;
            if (exp_req.size() == 0) begin
                chk("req_unexpected", exp_req.size(), 1);
            end else begin
                ea = exp_req.pop_front();
                chk("req_addr", oAddress, ea);
                chk("req_bc", oBurstcount, 24);
                pend_exp = ea;
            end
            pend_addr = oAddress; pend_left = 24; pend_k = 0; pend_delay = 1; stray = 0;
        end
        if (oWordValid === 1'b1 && iWordReady) begin
            pops++;
            if (sb_q.size() == 0) begin
                chk("sb_empty", sb_q.size(), 1);
            end else begin
                e = sb_q.pop_front();
                chk("word_data", oWordData, e.d);
                chk("word_idx", oWordIdx, e.idx);
                chk("word_last", oWordLast, (e.idx == 5'd23));
            end
        end
        @(posedge clk);
        #1;
        iStart = 1'b0;
        iWaitrequest = (wait_left > 0);
        iDatavalid = 1'b0;
        iData = 32'h0;
        if (pend_left > 0) begin
            if (pend_delay > 0) begin
                pend_delay--;
            end else if (beat_gap && gap_tog) begin
                gap_tog = 0;
            end else begin
                gap_tog = 1;
                iDatavalid = 1'b1;
                iData = ram_word(pend_addr + 32'(pend_k * 4));
                if (!stray) begin
                    e.d = ram_word(pend_exp + 32'(pend_k * 4));
                    e.idx = 5'(pend_k);
                    sb_q.push_back(e);
                end
                pend_k++; pend_left--; beats_drv++;
            end
        end
    endtask

    task automatic start_job(input logic [31:0] base, input logic [15:0] cnt);
        for (int i = 0; i < int'(cnt); i++) exp_req.push_back(base + 32'(i * 96));
        iBaseAddress = base;
        iFaceCount = cnt;
        iStart = 1'b1;
        tick();
    endtask

    task automatic run_until_done(input string tag, input int maxc);
        int d0 = done_cnt;
        int n = 0;
        while (done_cnt == d0 && n < maxc) begin
            tick();
            n++;
        end
        chk(tag, done_cnt - d0, 1);
    endtask

    initial begin
        int a0, p0, d0, r0, s0, b0, n;
        reset = 1'b1; iStart = 1'b0; iBaseAddress = '0; iFaceCount = '0;
        iWaitrequest = 1'b0; iData = '0; iDatavalid = 1'b0; iWordReady = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("rst_ctrl", {s_busy, s_done, s_read, s_wv, s_last, s_ovf}, 0);
        chk("rst_addr", s_addr, 0);
        chk("rst_bc", s_bc, 0);
        chk("rst_wdata", s_wdata, 0);
        chk("rst_widx", s_widx, 0);

        // single face, consumer always ready
        iWordReady = 1'b1;
        a0 = acc_cnt; p0 = pops;
        start_job(32'h30, 16'd1);
        tick();
        chk("t1_lat_read", s_read, 1);
        chk("t1_lat_busy", s_busy, 1);
        run_until_done("t1_done", 200);
        tick();
        chk("t1_idle", {s_busy, s_done}, 0);
        chk("t1_reqs", acc_cnt - a0, 1);
        chk("t1_words", pops - p0, 24);
        chk("t1_sb", sb_q.size(), 0);

        // three faces with gapped beats
        beat_gap = 1;
        a0 = acc_cnt; p0 = pops;
        start_job(32'h30, 16'd3);
        run_until_done("t2_done", 600);
        beat_gap = 0;
        chk("t2_reqs", acc_cnt - a0, 3);
        chk("t2_words", pops - p0, 72);
        chk("t2_sb", sb_q.size(), 0);

        // waitrequest held for five cycles on the request
        wait_left = 5;
        a0 = acc_cnt; p0 = pops; s0 = stall_cnt;
        start_job(32'h200, 16'd1);
        run_until_done("t3_done", 200);
        chk("t3_stalls", stall_cnt - s0, 5);
        chk("t3_reqs", acc_cnt - a0, 1);
        chk("t3_words", pops - p0, 24);

        // backpressure: second request only once 16 words have been drained
        iWordReady = 1'b0;
        a0 = acc_cnt; p0 = pops;
        start_job(32'h1000, 16'd3);
        repeat (40) tick();
        chk("t4_first_req", acc_cnt - a0, 1);
        chk("t4_valid", s_wv, 1);
        chk("t4_idx0", s_widx, 0);
        r0 = read_cycles;
        repeat (20) tick();
        chk("t4_no_read", read_cycles - r0, 0);
        iWordReady = 1'b1;
        n = 0;
        while (pops - p0 < 16 && n < 100) begin tick(); n++; end
        iWordReady = 1'b0;
        chk("t4_popped", pops - p0, 16);
        n = 0;
        while (acc_cnt - a0 < 2 && n < 10) begin tick(); n++; end
        chk("t4_second_req", acc_cnt - a0, 2);
        repeat (40) tick();
        iWordReady = 1'b1;
        run_until_done("t4_done", 400);
        chk("t4_words", pops - p0, 72);
        chk("t4_ovf", s_ovf, 0);

        // zero faces
        a0 = acc_cnt; r0 = read_cycles; d0 = done_cnt;
        start_job(32'h30, 16'd0);
        tick();
        chk("t5_done", {s_done, s_busy, s_read}, 3'b110);
        tick();
        chk("t5_after", {s_done, s_busy}, 0);
        chk("t5_reads", read_cycles - r0, 0);
        chk("t5_donecnt", done_cnt - d0, 1);

        // reset in the middle of a burst
        b0 = beats_drv;
        start_job(32'h400, 16'd2);
        n = 0;
        while (beats_drv - b0 < 10 && n < 50) begin tick(); n++; end
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sb_q.delete();
        exp_req.delete();
        stray = 1;
        tick();
        chk("t6_rst_ctrl", {s_busy, s_done, s_read, s_wv, s_last, s_ovf}, 0);
        chk("t6_rst_addr", s_addr, 0);
        chk("t6_rst_wdata", s_wdata, 0);
        chk("t6_rst_widx", s_widx, 0);
        n = 0;
        while (pend_left > 0 && n < 50) begin tick(); n++; end
        tick();
        chk("t6_stray_ovf", s_ovf, 0);
        chk("t6_stray_valid", {s_wv, s_busy}, 0);
        a0 = acc_cnt; p0 = pops;
        start_job(32'h30, 16'd1);
        run_until_done("t6_done", 200);
        chk("t6_reqs", acc_cnt - a0, 1);
        chk("t6_words", pops - p0, 24);
        tick();
        chk("t6_ovf", s_ovf, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
